// File: rtl/regbank_writer.sv
// -----------------------------------------------------------------------------
// regbank_writer
// Write-back buffer for the 64-bit register bank. Results arrive through a
// valid/ready handshake and are queued in a small FIFO. The FIFO drains one
// entry per cycle into a registered write port (c, w, dataC). Both bank read
// addresses are forwarded against every pending write, so readers see results
// that have not reached the bank yet.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   in_valid/in_ready   producer handshake; in_ready = rst_n && !full
//   in_addr, in_data    destination register and value of the incoming result
//   stall               1 = do not drain this cycle
//   c, w, dataC         registered bank write port; w pulses once per entry
//   a, b                bank read addresses to forward against
//   fwdA_hit/fwdA_data  youngest pending write to a (data 0 when no hit)
//   fwdB_hit/fwdB_data  same for b
//   count, empty, full  FIFO occupancy
// -----------------------------------------------------------------------------
module regbank_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       stall,
  output logic [AW-1:0]              c,
  output logic                       w,
  output logic [DW-1:0]              dataC,
  input  logic [AW-1:0]              a,
  input  logic [AW-1:0]              b,
  output logic                       fwdA_hit,
  output logic [DW-1:0]              fwdA_data,
  output logic                       fwdB_hit,
  output logic [DW-1:0]              fwdB_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addrMem [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];

  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] countReg;

  logic [AW-1:0] cReg;
  logic          wReg;
  logic [DW-1:0] dataCReg;

  logic          push;
  logic          pop;
  logic [DEPTH-1:0] slotValid;

  assign empty    = (countReg == '0);
  assign full     = (countReg == CW'(DEPTH));
  assign count    = countReg;
  assign in_ready = rst_n && !full;

  assign push = in_valid && in_ready;
  assign pop  = !empty && !stall;

  assign c     = cReg;
  assign w     = wReg;
  assign dataC = dataCReg;

  // Storage has no reset: slot validity comes from head/count, so stale
  // contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[tailPtr] <= in_addr;
      dataMem[tailPtr] <= in_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      countReg <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      case ({push, pop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cReg     <= '0;
      wReg     <= 1'b0;
      dataCReg <= '0;
    end else begin
      wReg <= pop;
      if (pop) begin
        cReg     <= addrMem[headPtr];
        dataCReg <= dataMem[headPtr];
      end
    end
  end

  // A slot holds a pending entry when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
    logic [PW-1:0] slotOffset;
    assign slotOffset    = PW'(gi) - headPtr;
    assign slotValid[gi] = (CW'(slotOffset) < countReg);
  end

  // Walk from the output register (oldest) through the FIFO head to tail so
  // that each later match overrides an earlier one: the youngest write wins.
  // A stalled output register (w=0) has already committed and is skipped.
  always_comb begin
    logic [PW-1:0] idx;
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    idx       = '0;
    if (wReg && cReg == a) begin
      fwdA_hit  = 1'b1;
      fwdA_data = dataCReg;
    end
    if (wReg && cReg == b) begin
      fwdB_hit  = 1'b1;
      fwdB_data = dataCReg;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = headPtr + PW'(k);
      if (slotValid[idx] && addrMem[idx] == a) begin
        fwdA_hit  = 1'b1;
        fwdA_data = dataMem[idx];
      end
      if (slotValid[idx] && addrMem[idx] == b) begin
        fwdB_hit  = 1'b1;
        fwdB_data = dataMem[idx];
      end
    end
  end

endmodule

// File: tb/tb_regbank_writer.sv
module tb_regbank_writer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          stall;
  logic [AW-1:0] c;
  logic          w;
  logic [DW-1:0] dataC;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic          fwdA_hit;
  logic [DW-1:0] fwdA_data;
  logic          fwdB_hit;
  logic [DW-1:0] fwdB_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  regbank_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .stall(stall),
    .c(c), .w(w), .dataC(dataC),
    .a(a), .b(b),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
    .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [AW+DW-1:0] expQ [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushOne(input logic [AW-1:0] ad, input logic [DW-1:0] da, input bit accepted);
    in_valid = 1'b1;
    in_addr  = ad;
    in_data  = da;
    if (accepted) expQ.push_back({ad, da});
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every bank write must match the oldest expected write.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (w) begin
        if (expQ.size() == 0) begin
          check("unexpected_write", {59'd0, c}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          $display("write c=%0d dataC=%h (expected c=%0d dataC=%h)", c, dataC, e[AW+DW-1:DW], e[DW-1:0]);
          check("write_addr", {59'd0, c}, {59'd0, e[AW+DW-1:DW]});
          check("write_data", dataC, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    stall    = 1'b0;
    a        = '0;
    b        = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_w",        {63'd0, w},        64'd0);
    check("rst_count",    {61'd0, count},    64'd0);
    check("rst_empty",    {63'd0, empty},    64'd1);
    check("rst_full",     {63'd0, full},     64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_c",        {59'd0, c},        64'd0);
    check("rst_dataC",    dataC,             64'd0);
    check("rst_fwdA_hit", {63'd0, fwdA_hit}, 64'd0);
    #9 rst_n = 1'b1;
    #1;
    check("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Single write: push at edge 1, w=1 after edge 2, w=0 after edge 3.
    pushOne(5'd3, 64'h1122334455667788, 1'b1);
    check("single_count1", {61'd0, count}, 64'd1);
    check("single_no_bypass", {63'd0, w}, 64'd0);
    tick();
    check("single_w", {63'd0, w}, 64'd1);
    check("single_c", {59'd0, c}, 64'd3);
    check("single_dataC", dataC, 64'h1122334455667788);
    tick();
    check("single_w_drop", {63'd0, w}, 64'd0);
    check("single_count0", {61'd0, count}, 64'd0);

    // Fill while stalled, then backpressure and ordered drain.
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) pushOne(AW'(i), 64'(i * 16), 1'b1);
    check("fill_full", {63'd0, full}, 64'd1);
    check("fill_ready", {63'd0, in_ready}, 64'd0);
    check("fill_count", {61'd0, count}, 64'd4);
    pushOne(5'd5, 64'h50, 1'b0);
    check("fill_reject_count", {61'd0, count}, 64'd4);
    check("stall_hold_w", {63'd0, w}, 64'd0);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_w", {63'd0, w}, 64'd1);
      check("drain_c", {59'd0, c}, 64'(i));
    end
    tick();
    check("drain_w_end", {63'd0, w}, 64'd0);
    check("drain_empty", {63'd0, empty}, 64'd1);

    // Forwarding priority: youngest of two writes to the same register.
    stall = 1'b1;
    pushOne(5'd7, 64'hAA, 1'b1);
    pushOne(5'd7, 64'hBB, 1'b1);
    a = 5'd7;
    b = 5'd8;
    #1;
    check("fwd_a_hit", {63'd0, fwdA_hit}, 64'd1);
    check("fwd_a_data", fwdA_data, 64'hBB);
    check("fwd_b_hit", {63'd0, fwdB_hit}, 64'd0);
    check("fwd_b_data", fwdB_data, 64'd0);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    check("fwd_after_pop_hit", {63'd0, fwdA_hit}, 64'd1);
    check("fwd_after_pop_data", fwdA_data, 64'hBB);
    stall = 1'b0;
    tick();
    check("fwd_outreg_data", fwdA_data, 64'hBB);
    tick();
    check("fwd_drained_hit", {63'd0, fwdA_hit}, 64'd0);

    // Output-register forwarding.
    a = 5'd9;
    pushOne(5'd9, 64'h55, 1'b1);
    check("oreg_fifo_hit", {63'd0, fwdA_hit}, 64'd1);
    check("oreg_fifo_data", fwdA_data, 64'h55);
    tick();
    check("oreg_w", {63'd0, w}, 64'd1);
    check("oreg_hit", {63'd0, fwdA_hit}, 64'd1);
    check("oreg_data", fwdA_data, 64'h55);
    tick();
    check("oreg_gone_hit", {63'd0, fwdA_hit}, 64'd0);
    check("oreg_gone_data", fwdA_data, 64'd0);

    // Streaming with simultaneous push/pop and pointer wrap.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(10 + i);
      in_data  = 64'h100 + 64'(i);
      expQ.push_back({in_addr, in_data});
      tick();
      check("stream_count", {61'd0, count}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_last_w", {63'd0, w}, 64'd1);
    check("stream_last_c", {59'd0, c}, 64'd19);
    tick();
    check("stream_empty", {63'd0, empty}, 64'd1);

    // Asynchronous reset mid-drain.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) pushOne(AW'(20 + i), 64'hC0 + 64'(i), 1'b1);
    stall = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_w", {63'd0, w}, 64'd0);
    check("arst_count", {61'd0, count}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd0);
    expQ.delete();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_w", {63'd0, w}, 64'd0);
      check("post_rst_count", {61'd0, count}, 64'd0);
    end

    tick();
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
